// File: rtl/rf_wb_pkg.sv
// Shared defaults and helpers for the register-file write-back arbiter.
// Optional build macro RF_WB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
package rf_wb_pkg;

  localparam int WIDTH_D    = 32;
  localparam int DEPTH_D    = 32;
  localparam int AD_WIDTH_D = 5;
  localparam int N_REQ_D    = 3;
  localparam int ID_W       = $clog2(N_REQ_D);

  // Pointer moves one past the winner so the winner becomes lowest priority next time.
  function automatic int unsigned rr_next_ptr(input int unsigned winner, input int unsigned n_req);
    if (winner + 32'd1 >= n_req) begin
      return 32'd0;
    end else begin
      return winner + 32'd1;
    end
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Write-back bus between execution-unit requesters and the shared register-file write port.
// Behaviour is independent of RF_WB_FIXED_PRIO_EN.
interface rf_wb_arbiter_if
  import rf_wb_pkg::*;
#(
  parameter int WIDTH    = WIDTH_D,
  parameter int DEPTH    = DEPTH_D,
  parameter int AD_WIDTH = AD_WIDTH_D,
  parameter int N_REQ    = N_REQ_D
);
  localparam int GID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ-1:0]          req_ready;
  logic [N_REQ*AD_WIDTH-1:0] req_addr;
  logic [N_REQ*WIDTH-1:0]    req_data;
  logic                      Wr_En;
  logic [AD_WIDTH-1:0]       A3;
  logic [WIDTH-1:0]          WData;
  logic [DEPTH-1:0]          busy;
  logic [GID_W-1:0]          grant_id;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, Wr_En, A3, WData, busy, grant_id
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, Wr_En, A3, WData, busy, grant_id
  );

endinterface

// File: rtl/rf_wb_arbiter_rr.sv
// Combinational arbiter: picks the first valid requester at/after ptr (wrapping).
// With RF_WB_FIXED_PRIO_EN defined the lowest valid index always wins and ptr is ignored.
module rr_arbiter
  import rf_wb_pkg::*;
#(
  parameter int N_REQ = N_REQ_D,
  parameter int GID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [GID_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [GID_W-1:0] grant_idx,
  output logic             grant_vld
);

`ifdef RF_WB_FIXED_PRIO_EN
  logic unused_ptr_s;
  assign unused_ptr_s = ^ptr;
`endif

  // Smallest priority distance among valid requesters wins.
  always_comb begin
    int dist_s;
    int best_s;
    grant     = {N_REQ{1'b0}};
    grant_idx = {GID_W{1'b0}};
    grant_vld = 1'b0;
    best_s    = N_REQ;
    dist_s    = 0;
    for (int i = 0; i < N_REQ; i++) begin
`ifdef RF_WB_FIXED_PRIO_EN
      dist_s = i;
`else
      dist_s = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + N_REQ - int'(ptr));
`endif
      if (valid[i] && (dist_s < best_s)) begin
        best_s    = dist_s;
        grant_idx = GID_W'(i);
        grant_vld = 1'b1;
      end else begin
        best_s = best_s;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      grant[i] = grant_vld & (grant_idx == GID_W'(i));
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between N_REQ one-entry write-back buffers.
// Build macro RF_WB_FIXED_PRIO_EN: fixed priority (no pointer) instead of round-robin.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int WIDTH    = WIDTH_D,
  parameter int DEPTH    = DEPTH_D,
  parameter int AD_WIDTH = AD_WIDTH_D,
  parameter int N_REQ    = N_REQ_D
) (
  input  logic           clk,
  input  logic           res,
  rf_wb_arbiter_if.slave bus
);
  localparam int GID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]                buf_valid_r, buf_valid_n;
  logic [N_REQ-1:0][AD_WIDTH-1:0]  buf_addr_r, buf_addr_n;
  logic [N_REQ-1:0][WIDTH-1:0]     buf_data_r, buf_data_n;
  logic                            wr_en_r, wr_en_n;
  logic [AD_WIDTH-1:0]             a3_r, a3_n;
  logic [WIDTH-1:0]                wdata_r, wdata_n;
  logic [GID_W-1:0]                grant_id_r, grant_id_n;
  logic [DEPTH-1:0]                busy_r, busy_n;
  logic [GID_W-1:0]                ptr_s;
  logic [N_REQ-1:0]                grant_s;
  logic [GID_W-1:0]                gidx_s;
  logic                            grant_vld_s;
  logic [N_REQ-1:0]                ready_s;
  logic [N_REQ-1:0]                xfer_s;

  rr_arbiter #(.N_REQ(N_REQ), .GID_W(GID_W)) u_arb (
    .valid     (buf_valid_r),
    .ptr       (ptr_s),
    .grant     (grant_s),
    .grant_idx (gidx_s),
    .grant_vld (grant_vld_s)
  );

  // A granted buffer drains this edge, so it can accept a refill in the same cycle.
  assign ready_s = {N_REQ{res}} & (~buf_valid_r | grant_s);
  assign xfer_s  = bus.req_valid & ready_s;

`ifdef RF_WB_FIXED_PRIO_EN
  assign ptr_s = {GID_W{1'b0}};
`else
  logic [GID_W-1:0] ptr_r;

  // Round-robin pointer advances past each winner and holds when idle.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      ptr_r <= {GID_W{1'b0}};
    end else if (grant_vld_s) begin
      ptr_r <= GID_W'(rr_next_ptr(32'(gidx_s), N_REQ));
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr_s = ptr_r;
`endif

  // Next buffer contents, write-port values and busy map.
  always_comb begin
    buf_valid_n = buf_valid_r;
    buf_addr_n  = buf_addr_r;
    buf_data_n  = buf_data_r;
    for (int i = 0; i < N_REQ; i++) begin
      // Writes to register 0 are accepted but never buffered.
      if (xfer_s[i] && (bus.req_addr[i*AD_WIDTH +: AD_WIDTH] != {AD_WIDTH{1'b0}})) begin
        buf_valid_n[i] = 1'b1;
        buf_addr_n[i]  = bus.req_addr[i*AD_WIDTH +: AD_WIDTH];
        buf_data_n[i]  = bus.req_data[i*WIDTH +: WIDTH];
      end else if (grant_s[i]) begin
        buf_valid_n[i] = 1'b0;
      end else begin
        buf_valid_n[i] = buf_valid_r[i];
      end
    end

    if (grant_vld_s) begin
      wr_en_n    = 1'b1;
      a3_n       = buf_addr_r[gidx_s];
      wdata_n    = buf_data_r[gidx_s];
      grant_id_n = gidx_s;
    end else begin
      wr_en_n    = 1'b0;
      a3_n       = a3_r;
      wdata_n    = wdata_r;
      grant_id_n = {GID_W{1'b0}};
    end

    busy_n = {DEPTH{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      busy_n[buf_addr_n[i]] = busy_n[buf_addr_n[i]] | buf_valid_n[i];
    end
    busy_n[a3_n] = busy_n[a3_n] | wr_en_n;
    busy_n[0]    = 1'b0;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      buf_valid_r <= {N_REQ{1'b0}};
      buf_addr_r  <= '{default: {AD_WIDTH{1'b0}}};
      buf_data_r  <= '{default: {WIDTH{1'b0}}};
      wr_en_r     <= 1'b0;
      a3_r        <= {AD_WIDTH{1'b0}};
      wdata_r     <= {WIDTH{1'b0}};
      grant_id_r  <= {GID_W{1'b0}};
      busy_r      <= {DEPTH{1'b0}};
    end else begin
      buf_valid_r <= buf_valid_n;
      buf_addr_r  <= buf_addr_n;
      buf_data_r  <= buf_data_n;
      wr_en_r     <= wr_en_n;
      a3_r        <= a3_n;
      wdata_r     <= wdata_n;
      grant_id_r  <= grant_id_n;
      busy_r      <= busy_n;
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.Wr_En     = wr_en_r;
  assign bus.A3        = a3_r;
  assign bus.WData     = wdata_r;
  assign bus.grant_id  = grant_id_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: constant vector table, directed corner cases,
// and randomized traffic against a cycle-level reference model.
module tb_rf_wb_arbiter;
  import rf_wb_pkg::*;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;
  localparam int N  = 3;

  logic clk = 1'b0;
  logic res = 1'b0;

  rf_wb_arbiter_if #(.WIDTH(W), .DEPTH(D), .AD_WIDTH(AW), .N_REQ(N)) bus ();

  rf_wb_arbiter #(.WIDTH(W), .DEPTH(D), .AD_WIDTH(AW), .N_REQ(N)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: buffer contents, pointer and write-port state as plain variables.
  bit           mv [N];
  int           ma [N];
  logic [W-1:0] md [N];
  int           mptr;
  bit           mwe;
  int           ma3;
  logic [W-1:0] mwd;
  int           mgid;

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 1'b0; ma[i] = 0; md[i] = '0;
    end
    mptr = 0; mwe = 1'b0; ma3 = 0; mwd = '0; mgid = 0;
  endtask

  function automatic int m_winner();
    for (int dd = 0; dd < N; dd++) begin
      int j;
`ifdef RF_WB_FIXED_PRIO_EN
      j = dd;
`else
      j = (mptr + dd) % N;
`endif
      if (mv[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    int w;
    w = m_winner();
    for (int i = 0; i < N; i++) r[i] = !mv[i] || (w == i);
    return r;
  endfunction

  function automatic logic [D-1:0] m_busy();
    logic [D-1:0] b;
    b = '0;
    for (int i = 0; i < N; i++) if (mv[i]) b[ma[i]] = 1'b1;
    if (mwe) b[ma3] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  task automatic m_update(input logic [N-1:0] v, input logic [N*AW-1:0] a, input logic [N*W-1:0] d);
    int w;
    logic [N-1:0] rdy;
    int wa;
    logic [W-1:0] wd;
    w = m_winner();
    rdy = m_ready();
    wa = 0; wd = '0;
    if (w >= 0) begin
      wa = ma[w]; wd = md[w]; mv[w] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (v[i] && rdy[i] && (a[i*AW +: AW] != 5'd0)) begin
        mv[i] = 1'b1; ma[i] = int'(a[i*AW +: AW]); md[i] = d[i*W +: W];
      end
    end
    if (w >= 0) begin
      mwe = 1'b1; ma3 = wa; mwd = wd; mgid = w; mptr = (w + 1) % N;
    end else begin
      mwe = 1'b0; mgid = 0;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".ready"}, 64'(bus.req_ready), 64'(m_ready()));
    chk({tag, ".wr_en"}, 64'(bus.Wr_En), 64'(mwe));
    chk({tag, ".a3"}, 64'(bus.A3), 64'(ma3));
    chk({tag, ".wdata"}, 64'(bus.WData), 64'(mwd));
    chk({tag, ".gid"}, 64'(bus.grant_id), 64'(mgid));
    chk({tag, ".busy"}, 64'(bus.busy), 64'(m_busy()));
  endtask

  // Drive inputs on the falling edge, check just after, advance model at the rising edge.
  task automatic cyc(input logic [N-1:0] v, input logic [N*AW-1:0] a, input logic [N*W-1:0] d, input string tag);
    @(negedge clk);
    bus.req_valid = v; bus.req_addr = a; bus.req_data = d;
    #1;
    check_model(tag);
    @(posedge clk);
    m_update(v, a, d);
  endtask

  typedef struct {
    logic [N-1:0]    v;
    logic [N*AW-1:0] a;
    logic [N*W-1:0]  d;
    logic [N-1:0]    e_rdy;
    logic            e_we;
    logic [AW-1:0]   e_a3;
    logic [W-1:0]    e_wd;
    logic [1:0]      e_gid;
    logic [D-1:0]    e_busy;
  } vec_t;

  vec_t tbl [10];

  function automatic vec_t mk(input logic [N-1:0] v, input logic [N*AW-1:0] a, input logic [N*W-1:0] d,
                              input logic [N-1:0] r, input logic we, input logic [AW-1:0] a3,
                              input logic [W-1:0] wd, input logic [1:0] g, input logic [D-1:0] b);
    vec_t t;
    t.v = v; t.a = a; t.d = d; t.e_rdy = r; t.e_we = we; t.e_a3 = a3; t.e_wd = wd; t.e_gid = g; t.e_busy = b;
    return t;
  endfunction

  initial begin
    logic [W-1:0] da, db, dc, dd, de, df;
    logic [N*AW-1:0] z_a;
    logic [N*W-1:0]  z_d;
    z_a = '0; z_d = '0;
    da = 32'hA0A0_0001; db = 32'hB0B0_0002; dc = 32'hC0C0_0003;
    dd = 32'hD0D0_0004; de = 32'hE0E0_0005; df = 32'hF0F0_0006;

    // Contention table: expected values are pre-edge outputs of each row's cycle.
    tbl[0] = mk(3'b111, {5'd3, 5'd2, 5'd1}, {dc, db, da}, 3'b111, 1'b0, 5'd0, 32'h0, 2'd0, 32'h0000_0000);
    tbl[1] = mk(3'b000, z_a, z_d, 3'b001, 1'b0, 5'd0, 32'h0, 2'd0, 32'h0000_000E);
    tbl[2] = mk(3'b000, z_a, z_d, 3'b011, 1'b1, 5'd1, da, 2'd0, 32'h0000_000E);
    tbl[3] = mk(3'b000, z_a, z_d, 3'b111, 1'b1, 5'd2, db, 2'd1, 32'h0000_000C);
    tbl[4] = mk(3'b111, {5'd6, 5'd5, 5'd4}, {df, de, dd}, 3'b111, 1'b1, 5'd3, dc, 2'd2, 32'h0000_0008);
    tbl[5] = mk(3'b000, z_a, z_d, 3'b001, 1'b0, 5'd3, dc, 2'd0, 32'h0000_0070);
    tbl[6] = mk(3'b000, z_a, z_d, 3'b011, 1'b1, 5'd4, dd, 2'd0, 32'h0000_0070);
    tbl[7] = mk(3'b000, z_a, z_d, 3'b111, 1'b1, 5'd5, de, 2'd1, 32'h0000_0060);
    tbl[8] = mk(3'b000, z_a, z_d, 3'b111, 1'b1, 5'd6, df, 2'd2, 32'h0000_0040);
    tbl[9] = mk(3'b000, z_a, z_d, 3'b111, 1'b0, 5'd6, df, 2'd0, 32'h0000_0000);

    bus.req_valid = 3'b111; bus.req_addr = z_a; bus.req_data = z_d;
    m_reset();

    // Reset held low with all requesters asserting valid.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk("rst.ready", 64'(bus.req_ready), 64'd0);
      chk("rst.wr_en", 64'(bus.Wr_En), 64'd0);
      chk("rst.busy", 64'(bus.busy), 64'd0);
    end
    @(negedge clk);
    bus.req_valid = 3'b000;
    res = 1'b1;
    @(posedge clk); #2;
    chk("rst.ready_after", 64'(bus.req_ready), 64'h7);

    // Constant-vector contention rounds.
    for (int r = 0; r < 10; r++) begin
      @(negedge clk);
      bus.req_valid = tbl[r].v; bus.req_addr = tbl[r].a; bus.req_data = tbl[r].d;
      #1;
      chk($sformatf("tbl%0d.ready", r), 64'(bus.req_ready), 64'(tbl[r].e_rdy));
      chk($sformatf("tbl%0d.wr_en", r), 64'(bus.Wr_En), 64'(tbl[r].e_we));
      chk($sformatf("tbl%0d.a3", r), 64'(bus.A3), 64'(tbl[r].e_a3));
      chk($sformatf("tbl%0d.wdata", r), 64'(bus.WData), 64'(tbl[r].e_wd));
      chk($sformatf("tbl%0d.gid", r), 64'(bus.grant_id), 64'(tbl[r].e_gid));
      chk($sformatf("tbl%0d.busy", r), 64'(bus.busy), 64'(tbl[r].e_busy));
      @(posedge clk);
      m_update(tbl[r].v, tbl[r].a, tbl[r].d);
    end

    // Single write from requester 1.
    cyc(3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEAD_BEEF, 32'h0}, "single0");
    #2;
    chk("single.busy5_k", 64'(bus.busy[5]), 64'd1);
    chk("single.wr_en_k", 64'(bus.Wr_En), 64'd0);
    cyc(3'b000, z_a, z_d, "single1");
    #2;
    chk("single.wr_en_k1", 64'(bus.Wr_En), 64'd1);
    chk("single.a3_k1", 64'(bus.A3), 64'd5);
    chk("single.wdata_k1", 64'(bus.WData), 64'hDEAD_BEEF);
    chk("single.gid_k1", 64'(bus.grant_id), 64'd1);
    cyc(3'b000, z_a, z_d, "single2");
    #2;
    chk("single.busy5_k2", 64'(bus.busy[5]), 64'd0);

    // Requester 0 streams one write per cycle.
    for (int s = 0; s < 8; s++) begin
      cyc(3'b001, {10'd0, 5'(s + 10)}, {64'h0, 32'h5000_0000 + 32'(s)}, $sformatf("stream%0d", s));
      #2;
      chk($sformatf("stream%0d.ready0", s), 64'(bus.req_ready[0]), 64'd1);
      if (s >= 1) begin
        chk($sformatf("stream%0d.wr_en", s), 64'(bus.Wr_En), 64'd1);
        chk($sformatf("stream%0d.wdata", s), 64'(bus.WData), 64'(32'h5000_0000 + 32'(s - 1)));
      end
    end
    cyc(3'b000, z_a, z_d, "stream_drain0");
    cyc(3'b000, z_a, z_d, "stream_drain1");

    // Write to register 0 is swallowed.
    cyc(3'b100, {5'd0, 5'd0, 5'd0}, {32'h0000_1234, 64'h0}, "zero0");
    for (int c = 0; c < 3; c++) begin
      #2;
      chk($sformatf("zero%0d.wr_en", c), 64'(bus.Wr_En), 64'd0);
      chk($sformatf("zero%0d.busy", c), 64'(bus.busy), 64'd0);
      cyc(3'b000, z_a, z_d, $sformatf("zero_idle%0d", c));
    end

    // Reset while two buffers are valid and the write port is active.
    cyc(3'b111, {5'd9, 5'd8, 5'd7}, {dc, db, da}, "mid0");
    cyc(3'b000, z_a, z_d, "mid1");
    #2;
    chk("mid.wr_en_before", 64'(bus.Wr_En), 64'd1);
    res = 1'b0;
    #1;
    chk("mid.wr_en_rst", 64'(bus.Wr_En), 64'd0);
    chk("mid.busy_rst", 64'(bus.busy), 64'd0);
    chk("mid.ready_rst", 64'(bus.req_ready), 64'd0);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    res = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cyc(3'b000, z_a, z_d, $sformatf("mid_after%0d", c));
      #2;
      chk($sformatf("mid_after%0d.wr_en", c), 64'(bus.Wr_En), 64'd0);
    end

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0]    rv;
      logic [N*AW-1:0] ra;
      logic [N*W-1:0]  rd;
      rv = 3'($urandom_range(0, 7));
      ra = 15'($urandom);
      rd = {$urandom, $urandom, $urandom};
      cyc(rv, ra, rd, $sformatf("rand%0d", c));
    end
    cyc(3'b000, z_a, z_d, "rand_end0");
    cyc(3'b000, z_a, z_d, "rand_end1");
    cyc(3'b000, z_a, z_d, "rand_end2");
    cyc(3'b000, z_a, z_d, "rand_end3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port (Wr_En/A3/WData) between N write-back requesters, e.g. ALU result, load data and multiply/divide unit.
- Each requester has a one-entry holding buffer with a valid/ready handshake. A round-robin arbiter drains the buffers into a registered write port.
- Exports a per-register busy vector so the hazard/stall logic can hold readers of registers with writes still in flight.
- Sits between the execution units and the register file.

Parameters:
- Width, 32, data word width
- Depth, 32, number of architectural registers
- AD_Width, 5, register address width (clog2 Depth)
- N_REQ, 3, number of write-back requesters (2..8)

Ports:
- clk  in  1  system clock, rising edge
- res  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  requester i presents a write
- req_ready  out  N_REQ  requester i's buffer can accept this cycle
- req_addr  in  N_REQ*AD_Width  destination register; slice i = bits [i*AD_Width +: AD_Width]
- req_data  in  N_REQ*Width  write data; slice i = bits [i*Width +: Width]
- Wr_En  out  1  register file write enable (registered)
- A3  out  AD_Width  register file write address (registered)
- WData  out  Width  register file write data (registered)
- busy  out  Depth  bit r=1: a write to register r is buffered or on the write port
- grant_id  out  clog2(N_REQ)  requester index of the current Wr_En pulse; 0 when idle

Behaviour:
- Reset (res low, asynchronous):
  - All buffers invalid; pending writes are discarded.
  - Round-robin pointer = 0.
  - Wr_En=0, A3=0, WData=0, grant_id=0, busy=0.
  - req_ready is forced to 0 while res is low.
- Handshake:
  - Transfer on requester i occurs when req_valid[i] & req_ready[i] at the rising edge.
  - req_ready[i] = ~buf_valid[i] | grant[i] (combinational), so a requester can stream one write per cycle while it is granted.
  - req_addr/req_data are sampled only on a transfer.
- Address 0:
  - A transfer with addr 0 is accepted but never enters the buffer; it is silently dropped and never produces a Wr_En pulse.
- Arbitration, each cycle, combinational over buf_valid:
  - Winner = first valid buffer at or after the pointer, in increasing index order with wrap.
  - On a grant at edge k, the winner's entry is loaded into A3/WData, Wr_En=1 and grant_id=winner at edge k.
  - The buffer is cleared, or refilled if the same requester transfers that edge.
  - Pointer <= winner+1 (mod N_REQ).
  - If no buffer is valid: Wr_En<=0, A3/WData hold their values, pointer holds.
- Latency: transfer at edge k -> earliest Wr_En high after edge k+1 -> register file updated at edge k+2.
- Throughput: one register write per cycle.
- Worst-case wait for a buffered entry: N_REQ grants.
- busy[r] = OR over i of (buf_valid[i] & buf_addr[i]==r) | (Wr_En & A3==r). busy[0] is always 0.
- Simultaneous same-address writes from different requesters: commit order is arbitration order. The arbiter gives no cross-requester ordering guarantee; per-requester order is preserved.

Optional Feature:
- Macro RF_WB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins every cycle; pointer logic is removed and starvation is permitted.
- Undefined: round-robin as above.
- Latency, handshake and busy behaviour are identical in both builds.

Decomposition:
- Package rf_wb_pkg holds:
  - defaults WIDTH_D=32, DEPTH_D=32, AD_WIDTH_D=5, N_REQ_D=3
  - localparam ID_W = clog2(N_REQ)
  - a function for the round-robin next-pointer computation
- One sub-module, rr_arbiter:
  - Ports: valid vector in, pointer in, one-hot grant plus index out.
  - Purely combinational; instantiated once.
  - The fixed-priority variant lives inside it under the macro.
- Buffers, pointer register and write-port registers stay in rf_wb_arbiter.

Test Plan:
- Reset: hold res low 3 cycles with req_valid=3'b111.
  - Required: req_ready=0, Wr_En=0, busy=0.
  - After release, ready=3'b111 on the next cycle.
- Single write: req 1 sends addr 5, data 0xDEADBEEF at edge k.
  - Required: busy[5]=1 from after edge k.
  - Wr_En=1, A3=5, WData=0xDEADBEEF, grant_id=1 in cycle k+1.
  - busy[5]=0 after edge k+2.
- Contention: all 3 requesters load addr 1/2/3 at the same edge.
  - Required: Wr_En pulses on 3 consecutive cycles in order A3=1,2,3 (pointer 0).
  - Next round starting at pointer 0 again, since 2+1 wraps to 0.
- Streaming: req 0 holds valid with a new addr each cycle while others are idle.
  - Required: ready stays 1 and Wr_En stays 1 every cycle.
  - Data appears in input order.
- Zero address: req 2 sends addr 0, data 0x1234.
  - Required: accepted, no Wr_En pulse, busy stays 0.
- Reset mid-flight: assert res low while 2 buffers are valid and Wr_En=1.
  - Required: Wr_En, busy and buffers clear immediately.
  - No write appears after release.
  - Under RF_WB_FIXED_PRIO_EN, repeating the contention test yields order 1,2,3 with req 0 winning every cycle it remains valid.
